// File: rtl/display_scheduler_if.sv
// Receiver-side byte strobe plus display-side outputs of display_scheduler, grouped as one bus.
interface display_scheduler_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perror;
    logic       rx_ferror;
    logic [7:0] disp_data;
    logic       disp_valid;
    logic       tick;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output rx_data, rx_valid, rx_perror, rx_ferror,
        input  disp_data, disp_valid, tick, fifo_full, overflow
    );

    modport slave (
        input  rx_data, rx_valid, rx_perror, rx_ferror,
        output disp_data, disp_valid, tick, fifo_full, overflow
    );
endinterface

// File: rtl/display_scheduler.sv
// FIFO-buffered byte scheduler for the 7-seg path: byte visible 3 cycles after strobe, dwell HOLD_TICKS ticks;
// no backpressure, a strobe into a full FIFO without a pop is dropped and sets sticky overflow. Option: DISPLAY_SCHED_ERROR_EN.
module display_scheduler #(
    parameter int TICK_DIV   = 4,
    parameter int HOLD_TICKS = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    display_scheduler_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TICK_DIV);
    localparam int HW    = $clog2(HOLD_TICKS + 1);
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

    state_t                state_q;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [HW-1:0]         hold_q;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            disp_data_q;
    logic                  disp_valid_q;
    logic                  overflow_q, overflow_d;
    logic                  tick, full, pop, push;
    logic [7:0]            push_dat;

`ifdef DISPLAY_SCHED_ERROR_EN
    assign push_dat = (bus.rx_perror || bus.rx_ferror) ? 8'h89 : bus.rx_data;
`else
    logic err_unused;
    assign err_unused = bus.rx_perror ^ bus.rx_ferror;
    assign push_dat   = bus.rx_data;
`endif

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign full = (count_q == CW'(DEPTH));
    assign pop  = (state_q == LOAD);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = bus.rx_valid && (!full || pop);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        overflow_d = overflow_q || (bus.rx_valid && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            disp_data_q  <= 8'h00;
            disp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0)
                        state_q <= LOAD;
                end
                LOAD: begin
                    disp_data_q  <= mem_q[rd_ptr_q];
                    disp_valid_q <= 1'b1;
                    hold_q       <= '0;
                    state_q      <= SHOW;
                end
                SHOW: begin
                    if (tick) begin
                        hold_q <= hold_q + 1'b1;
                        if (hold_q == HW'(HOLD_TICKS - 1)) begin
                            disp_valid_q <= 1'b0;
                            state_q      <= (count_q != '0) ? LOAD : IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.tick       = tick;
    assign bus.fifo_full  = full;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_display_scheduler.sv
// Directed-vector bench for display_scheduler; expected display bytes go to a queue checked by a negedge monitor.
module tb_display_scheduler;
    localparam int TD = 4;
    localparam int HT = 2;
    localparam int DL = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scheduler_if bus();

    display_scheduler #(
        .TICK_DIV   (TD),
        .HOLD_TICKS (HT),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         total = 0;
    int         bad = 0;
    int         shown = 0;
    bit         chk_gap = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [7:0] d, input logic err);
`ifdef DISPLAY_SCHED_ERROR_EN
        return err ? 8'h89 : d;
`else
        return err ? d : d;
`endif
    endfunction

    // Monitor: every rising edge of disp_valid presents one new byte.
    logic prev_v = 1'b0;
    int   run = 0;
    int   gap = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
            run    = 0;
            gap    = 0;
        end else begin
            if (bus.disp_valid && !prev_v) begin
                shown++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_show: got %0h want none", bus.disp_data);
                end else begin
                    check("show_data", bus.disp_data, exp_q.pop_front());
                end
                if (chk_gap)
                    check("gap_len", gap, 1);
                run = 1;
            end else if (bus.disp_valid) begin
                run++;
            end else if (prev_v) begin
                check("dwell_range", (run >= (HT-1)*TD+1) && (run <= HT*TD), 1);
                gap = 1;
            end else begin
                gap++;
            end
            prev_v = bus.disp_valid;
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic fe, input bit shows);
        if (shows)
            exp_q.push_back(glyph(d, pe | fe));
        bus.rx_data   = d;
        bus.rx_perror = pe;
        bus.rx_ferror = fe;
        bus.rx_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid  = 1'b0;
        bus.rx_perror = 1'b0;
        bus.rx_ferror = 1'b0;
    endtask

    task automatic wait_valid(input logic v, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (bus.disp_valid === v)
                hit = 1'b1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: disp_valid never reached %0b in %0d cycles", name, v, budget);
        end
    endtask

    task automatic drain(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.disp_valid === 1'b0)
                done = 1'b1;
        end
        check(name, done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.rx_perror = 1'b0;
        bus.rx_ferror = 1'b0;

        // Reset held for three cycles, then tick every 4th cycle.
        @(posedge clk);
        #1;
        check("rst_disp_data", bus.disp_data, 8'h00);
        check("rst_disp_valid", bus.disp_valid, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_fifo_full", bus.fifo_full, 0);
        check("rst_tick", bus.tick, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("tick_phase", bus.tick, (i % 4) == 3);
            @(posedge clk);
            #1;
        end

        // Single byte: visible at n+3, data held after the dwell.
        send(8'hAA, 1'b0, 1'b0, 1'b1);
        check("single_n1_valid", bus.disp_valid, 0);
        @(posedge clk);
        #1;
        check("single_n2_valid", bus.disp_valid, 0);
        @(posedge clk);
        #1;
        check("single_n3_valid", bus.disp_valid, 1);
        check("single_n3_data", bus.disp_data, 8'hAA);
        wait_valid(1'b0, 20, "single_end");
        check("single_hold_data", bus.disp_data, 8'hAA);
        drain(40, "single_drain");

        // Burst of six: sixth dropped, overflow sticky.
        do_reset(2);
        for (int i = 1; i <= 5; i++)
            send(8'(i), 1'b0, 1'b0, 1'b1);
        check("burst_full", bus.fifo_full, 1);
        check("burst_ovf_before", bus.overflow, 0);
        send(8'h06, 1'b0, 1'b0, 1'b0);
        check("burst_ovf_after", bus.overflow, 1);
        wait_valid(1'b1, 20, "burst_first");
        @(posedge clk);
        #1;
        chk_gap = 1'b1;
        drain(200, "burst_drain");
        chk_gap = 1'b0;
        check("burst_ovf_sticky", bus.overflow, 1);

        // Full FIFO with a push in the LOAD cycle.
        do_reset(2);
        for (int i = 0; i < 5; i++)
            send(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        check("fp_full", bus.fifo_full, 1);
        wait_valid(1'b1, 20, "fp_show");
        wait_valid(1'b0, 20, "fp_load");
        exp_q.push_back(8'h15);
        bus.rx_data  = 8'h15;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        check("fp_full_after", bus.fifo_full, 1);
        check("fp_ovf_after", bus.overflow, 0);
        @(posedge clk);
        #1;
        check("fp_full_later", bus.fifo_full, 1);
        check("fp_ovf_later", bus.overflow, 0);
        drain(300, "fp_drain");

        // Error-qualified bytes.
        do_reset(2);
        send(8'h55, 1'b0, 1'b1, 1'b1);
        send(8'h3C, 1'b1, 1'b0, 1'b1);
        send(8'h66, 1'b0, 1'b0, 1'b1);
        drain(200, "err_drain");

        // Reset during the first dwell discards the queue.
        do_reset(2);
        send(8'h21, 1'b0, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b0, 1'b0);
        send(8'h23, 1'b0, 1'b0, 1'b0);
        wait_valid(1'b1, 20, "mid_show");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_data", bus.disp_data, 8'h00);
        check("mid_rst_valid", bus.disp_valid, 0);
        check("mid_rst_full", bus.fifo_full, 0);
        check("mid_rst_ovf", bus.overflow, 0);
        reset = 1'b0;
        s = shown;
        repeat (60) @(posedge clk);
        #1;
        check("mid_no_replay", shown, s);
        check("mid_valid_low", bus.disp_valid, 0);
        check("mid_exp_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
